// File: rtl/tenkey_scanner.sv
// rtl/tenkey_scanner.sv - 4x3 keypad scanner with frame debounce and one-hot digit / close outputs
module tenkey_scanner #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic       ck,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [2:0] col,
  output logic [9:0] tenkey,
  output logic       close,
  output logic       multi
);

  localparam int SCW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 2;
  localparam int DBW = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
  localparam logic [SCW-1:0] SC_LAST = SCW'(SCAN_DIV - 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE - 1);
  // Snapshot bit k = row*3 + col; bit 11 is '#', which is never reported.
  localparam logic [11:0] KEY_MASK = 12'h7ff;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIGIT = 2'd1,
    ST_CLOSE = 2'd2,
    ST_MULTI = 2'd3
  } state_t;

  logic [3:0]     row_s1_q, row_s2_q;
  logic [SCW-1:0] sc_q, sc_d;
  logic [1:0]     ci_q, ci_d;
  logic [2:0]     col_q, col_d;
  logic [11:0]    frame_q, frame_d;
  logic [11:0]    prev_q, prev_d;
  logic [11:0]    acc_q, acc_d;
  logic [DBW-1:0] stable_q, stable_d;
  logic           acc_upd_q, acc_upd_d;
  logic [11:0]    snap;
  logic           sample;

  state_t         state_q, class_d;
  logic [9:0]     tenkey_q, digit_oh;
  logic           close_q, multi_q;
  logic [3:0]     n_keys;

  assign sample = (sc_q == SC_LAST);

  always_comb begin
    sc_d      = sample ? '0 : sc_q + SCW'(1);
    ci_d      = ci_q;
    frame_d   = frame_q;
    prev_d    = prev_q;
    acc_d     = acc_q;
    stable_d  = stable_q;
    acc_upd_d = 1'b0;
    if (sample) begin
      ci_d = (ci_q == 2'd2) ? 2'd0 : ci_q + 2'd1;
      for (int r = 0; r < 4; r++) begin
        case (ci_q)
          2'd0:    frame_d[r*3]     = row_s2_q[r];
          2'd1:    frame_d[r*3 + 1] = row_s2_q[r];
          2'd2:    frame_d[r*3 + 2] = row_s2_q[r];
          default: ;
        endcase
      end
    end
    col_d = 3'b001 << ci_d;
    snap  = frame_d & KEY_MASK;
    // Frame end: the column-2 sample has just completed the snapshot.
    if (sample && ci_q == 2'd2) begin
      if (snap == prev_q)
        stable_d = (stable_q == DB_LAST) ? stable_q : stable_q + DBW'(1);
      else
        stable_d = '0;
      prev_d = snap;
      if (stable_d == DB_LAST) begin
        acc_d     = snap;
        acc_upd_d = 1'b1;
      end
    end
  end

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      row_s1_q  <= '0;
      row_s2_q  <= '0;
      sc_q      <= '0;
      ci_q      <= '0;
      col_q     <= 3'b001;
      frame_q   <= '0;
      prev_q    <= '0;
      acc_q     <= '0;
      stable_q  <= '0;
      acc_upd_q <= 1'b0;
    end else begin
      row_s1_q  <= row;
      row_s2_q  <= row_s1_q;
      sc_q      <= sc_d;
      ci_q      <= ci_d;
      col_q     <= col_d;
      frame_q   <= frame_d;
      prev_q    <= prev_d;
      acc_q     <= acc_d;
      stable_q  <= stable_d;
      acc_upd_q <= acc_upd_d;
    end
  end

  always_comb begin
    n_keys   = '0;
    digit_oh = '0;
    for (int k = 0; k < 12; k++)
      n_keys = n_keys + 4'(acc_q[k]);
    for (int k = 0; k < 9; k++)
      digit_oh[k+1] = acc_q[k];
    digit_oh[0] = acc_q[10];
    if (n_keys == 4'd0)
      class_d = ST_IDLE;
    else if (n_keys >= 4'd2)
      class_d = ST_MULTI;
    else if (acc_q[9])
      class_d = ST_CLOSE;
    else
      class_d = ST_DIGIT;
  end

  // Re-classified every frame the snapshot is re-accepted; close only fires on entry.
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      tenkey_q <= '0;
      close_q  <= 1'b0;
      multi_q  <= 1'b0;
    end else if (acc_upd_q) begin
      state_q  <= class_d;
      tenkey_q <= (class_d == ST_DIGIT) ? digit_oh : '0;
      close_q  <= (class_d == ST_CLOSE) && (state_q != ST_CLOSE);
      multi_q  <= (class_d == ST_MULTI);
    end else begin
      close_q  <= 1'b0;
    end
  end

  assign col    = col_q;
  assign tenkey = tenkey_q;
  assign close  = close_q;
  assign multi  = multi_q;

endmodule

// File: doc/tenkey_scanner.md
Name: tenkey_scanner

Overview:
Matrix keypad front end that produces the tenkey and close inputs of the electronic lock. It drives a 4-row x 3-column keypad one column at a time and reads the row lines back. Each scan frame is debounced, and the accepted key is presented as a 10-bit one-hot digit level plus a single-cycle close pulse. It sits between the keypad pins and the lock core, on the same ck/reset domain.

Parameters:
SCAN_DIV, 4, clock cycles each column is driven; minimum 3, to cover the 2-flop row synchronizer.
DEBOUNCE, 3, consecutive identical frames required before a snapshot is accepted; minimum 2.

Ports:
ck  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
row  input  4  keypad row sense, active-high, asynchronous to ck.
col  output  3  keypad column drive, one-hot, active-high.
tenkey  output  10  one-hot accepted digit; bit n = digit n; 0 when no valid digit.
close  output  1  one-cycle pulse when '*' is accepted.
multi  output  1  level; accepted snapshot contains two or more keys.

Behaviour:
- Reset is asynchronous, active-high. Reset values: col=3'b001, tenkey=0, close=0, multi=0. Scan counter, column index, frame buffer, previous snapshot, accepted snapshot and stable counter all clear to 0.
- row passes through a 2-flop synchronizer before any use.
- Scan: a counter sc runs 0..SCAN_DIV-1 and a column index ci runs 0..2. col = one-hot(ci). ci advances when sc wraps, and ci wraps from 2 to 0.
- Sampling: at sc==SCAN_DIV-1, the synchronized row is written into the frame buffer bits for column ci.
- Frame end is the sample at ci==2, sc==SCAN_DIV-1. The frame is 3*SCAN_DIV cycles.
- Key map (row,col): (0,0)=1, (0,1)=2, (0,2)=3, (1,0)=4, (1,1)=5, (1,2)=6, (2,0)=7, (2,1)=8, (2,2)=9, (3,0)='*', (3,1)=0, (3,2)='#'.
- '#' is reserved. It is masked out of the snapshot and treated as not pressed.
- Debounce runs at each frame end, on the completed 12-bit snapshot S:
  - If S == previous snapshot, stable counter increments, saturating at DEBOUNCE-1.
  - Otherwise stable counter = 0.
  - previous snapshot is set to S.
  - When the counter reaches DEBOUNCE-1, the accepted snapshot is set to S.
- Classification of the accepted snapshot uses a state machine with states IDLE (0 keys), DIGIT (exactly one digit key), CLOSE (exactly '*'), MULTI (2 or more keys, '*' included in the count).
  - The state is re-evaluated only when the accepted snapshot updates.
  - Any state may transition to any other.
- Outputs are registered and change on the edge after the accepted snapshot updates.
  - tenkey = one-hot digit in DIGIT, 0 otherwise.
  - multi = 1 in MULTI only.
  - close = 1 for exactly one cycle on entry to CLOSE from any other state. It is not repeated while '*' stays held.
- Boundary conditions:
  - Direct change from digit A to digit B with no release: tenkey goes straight to one-hot(B), never both bits.
  - Release: tenkey returns to 0 after DEBOUNCE stable frames of no keys.
  - A glitch shorter than one frame never changes outputs.
  - Reset mid-frame aborts the scan; scanning restarts at column 0 and debouncing restarts from zero.
- Latency: with a key stable before a frame starts, outputs update no later than DEBOUNCE*3*SCAN_DIV + 3 cycles after the press.

Test Plan:
- Reset then idle, row=0 -> col cycles 001,010,100 every 4 cycles; tenkey=0, close=0, multi=0 throughout.
- Hold '5' (row[1] high whenever col[1] is driven) for 60 cycles -> tenkey=10'h020 within 39 cycles, stays constant; release -> tenkey=0 within 39 cycles.
- Hold '*' for 100 cycles -> close high for exactly one cycle; tenkey=0; no second pulse. Release and press again -> second pulse.
- Hold '1' and '9' together -> multi=1, tenkey=0. Release '9' -> multi=0, tenkey=10'h002.
- Press '3' with a 1-frame bounce (on/off/on before steady) -> tenkey stays 0 until 3 identical frames are seen, then 10'h008. Press '#' -> all outputs remain 0.
- Assert reset while '7' is accepted -> tenkey=0 and col=001 immediately. With '7' still held, tenkey=10'h080 again after 3 frames.
